control_unit_pipe: RTL

Pipelined successor to the single-cycle control unit. It decodes the full RV32I base set (R, I-load, I-ALU, JALR, S, B, AUIPC, LUI, JAL) into a control bundle and registers it into the ID/EX pipeline register. It detects load-use hazards against the instruction it currently holds in EX and stalls fetch for one cycle. It accepts a flush from EX on taken branches and jumps. Branch resolution moves to EX: the bundle carries a condition code instead of consuming EQ.

---
 rtl/control_unit_pipe_pkg.sv | 88 ++++++++
 rtl/control_unit_pipe_decode.sv | 132 +++++++++++++
 rtl/control_unit_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/control_unit_pipe_pkg.sv
// Shared types for the pipelined RV32I control unit: ALU ops, immediate formats,
// operand/result selects and the ID/EX control bundle.
package control_unit_pipe_pkg;

  localparam int unsigned RegIdxW = 5;

  typedef enum logic [3:0] {
    SUM_OP  = 4'd0,
    SUB_OP  = 4'd1,
    SLL_OP  = 4'd2,
    SLT_OP  = 4'd3,
    SLTU_OP = 4'd4,
    XOR_OP  = 4'd5,
    SRL_OP  = 4'd6,
    SRA_OP  = 4'd7,
    OR_OP   = 4'd8,
    AND_OP  = 4'd9
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    Imm    = 3'd0,
    Store  = 3'd1,
    Branch = 3'd2,
    Upper  = 3'd3,
    Jump   = 3'd4
  } instr_format_e;

  typedef enum logic [1:0] {
    ResAlu = 2'd0,
    ResMem = 2'd1,
    ResPc4 = 2'd2
  } result_src_e;

  typedef enum logic [1:0] {
    SrcARs1  = 2'd0,
    SrcAPc   = 2'd1,
    SrcAZero = 2'd2
  } src_a_e;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpAluImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpAluReg  = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] Funct7Alt = 7'b0100000;

  typedef struct packed {
    logic                valid;
    logic                illegal;
    logic                reg_write;
    alu_ctrl_e           alu_ctrl;
    src_a_e              alu_src_a;
    logic                alu_src_b;
    instr_format_e       imm_src;
    result_src_e         result_src;
    logic                mem_write;
    logic                mem_read;
    logic [2:0]          mem_size;
    logic                branch;
    logic [2:0]          br_cond;
    logic                jump;
    logic                jump_reg;
    logic [RegIdxW-1:0]  rs1;
    logic [RegIdxW-1:0]  rs2;
    logic [RegIdxW-1:0]  rd;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  // ALU op for funct3 when funct7 selects the base (non-alternate) operation.
  function automatic alu_ctrl_e alu_base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return SUM_OP;
      3'b001:  return SLL_OP;
      3'b010:  return SLT_OP;
      3'b011:  return SLTU_OP;
      3'b100:  return XOR_OP;
      3'b101:  return SRL_OP;
      3'b110:  return OR_OP;
      default: return AND_OP;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_pipe_decode.sv
// Combinational RV32I decode into a control bundle plus source-register usage flags
// for the load-use hazard check.
module control_unit_pipe_decode
  import control_unit_pipe_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         uses_rs1,
  output logic         uses_rs2
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl       = BUBBLE;
    ctrl.valid = 1'b1;
    ctrl.rs1   = instr[19:15];
    ctrl.rs2   = instr[24:20];
    ctrl.rd    = instr[11:7];
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    legal      = 1'b1;

    case (opcode)
      OpAluReg: begin
        ctrl.reg_write = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        if (funct7 == 7'b0000000) begin
          ctrl.alu_ctrl = alu_base_op(funct3);
        end else if (funct7 == Funct7Alt && funct3 == 3'b000) begin
          ctrl.alu_ctrl = SUB_OP;
        end else if (funct7 == Funct7Alt && funct3 == 3'b101) begin
          ctrl.alu_ctrl = SRA_OP;
        end else begin
          legal = 1'b0;
        end
      end
      OpAluImm: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = Imm;
        ctrl.alu_ctrl  = alu_base_op(funct3);
        uses_rs1       = 1'b1;
        if (funct3 == 3'b001) begin
          legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          if (funct7 == Funct7Alt) ctrl.alu_ctrl = SRA_OP;
          else                     legal = (funct7 == 7'b0000000);
        end
      end
      OpLoad: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.result_src = ResMem;
        ctrl.alu_src_b  = 1'b1;
        ctrl.imm_src    = Imm;
        ctrl.alu_ctrl   = SUM_OP;
        ctrl.mem_size   = funct3;
        uses_rs1        = 1'b1;
        legal           = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
      end
      OpStore: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = Store;
        ctrl.alu_ctrl  = SUM_OP;
        ctrl.mem_size  = funct3;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        legal          = !funct3[2] && (funct3 != 3'b011);
      end
      OpBranch: begin
        ctrl.branch   = 1'b1;
        ctrl.br_cond  = funct3;
        ctrl.imm_src  = Branch;
        ctrl.alu_ctrl = SUB_OP;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        legal         = (funct3[2:1] != 2'b01);
      end
      OpJal: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = ResPc4;
        ctrl.imm_src    = Jump;
      end
      OpJalr: begin
        ctrl.jump_reg   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = ResPc4;
        ctrl.alu_src_b  = 1'b1;
        ctrl.imm_src    = Imm;
        ctrl.alu_ctrl   = SUM_OP;
        uses_rs1        = 1'b1;
        legal           = (funct3 == 3'b000);
      end
      OpAuipc: begin
        ctrl.alu_src_a = SrcAPc;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = Upper;
        ctrl.alu_ctrl  = SUM_OP;
        ctrl.reg_write = 1'b1;
      end
      OpLui: begin
        ctrl.alu_src_a = SrcAZero;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_src   = Upper;
        ctrl.alu_ctrl  = SUM_OP;
        ctrl.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Illegal words still occupy a slot downstream but carry no side effects.
    if (!legal) begin
      ctrl         = BUBBLE;
      ctrl.valid   = 1'b1;
      ctrl.illegal = 1'b1;
      uses_rs1     = 1'b0;
      uses_rs2     = 1'b0;
    end
  end

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined RV32I control unit: decode, load-use stall detection and the ID/EX
// control register with flush/stall bubble insertion.
module control_unit_pipe
  import control_unit_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          HAZARD_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       instr_i,
  input  logic                  instr_valid_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic                  illegal_o,
  output logic                  reg_write_o,
  output logic [3:0]            alu_ctrl_o,
  output logic [1:0]            alu_src_a_o,
  output logic                  alu_src_b_o,
  output logic [2:0]            imm_src_o,
  output logic [1:0]            result_src_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  output logic [2:0]            mem_size_o,
  output logic                  branch_o,
  output logic [2:0]            br_cond_o,
  output logic                  jump_o,
  output logic                  jump_reg_o,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] rd_o
);

  if (XLEN != 32) begin : g_xlen_check
    $error("control_unit_pipe: XLEN must be 32");
  end
  if (REG_ADDR_W != RegIdxW) begin : g_reg_addr_check
    $error("control_unit_pipe: REG_ADDR_W must be 5");
  end

  ctrl_bundle_t dec;
  ctrl_bundle_t bundle_d;
  ctrl_bundle_t bundle_q;
  logic         uses_rs1;
  logic         uses_rs2;
  logic         load_in_ex;
  logic         rs1_hit;
  logic         rs2_hit;

  control_unit_pipe_decode u_decode (
    .instr    (instr_i[31:0]),
    .ctrl     (dec),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // Load data only arrives after EX, so a dependent instruction must wait one slot.
  assign load_in_ex = bundle_q.valid && bundle_q.mem_read && (bundle_q.rd != '0);
  assign rs1_hit    = uses_rs1 && (bundle_q.rd == dec.rs1);
  assign rs2_hit    = uses_rs2 && (bundle_q.rd == dec.rs2);
  assign stall_o    = HAZARD_EN && !rst && !flush_i && instr_valid_i && load_in_ex &&
                      (rs1_hit || rs2_hit);

  always_comb begin
    bundle_d = dec;
    if (flush_i || stall_o || !instr_valid_i) bundle_d = BUBBLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bundle_q <= BUBBLE;
    else     bundle_q <= bundle_d;
  end

  assign valid_o      = bundle_q.valid;
  assign illegal_o    = bundle_q.illegal;
  assign reg_write_o  = bundle_q.reg_write;
  assign alu_ctrl_o   = bundle_q.alu_ctrl;
  assign alu_src_a_o  = bundle_q.alu_src_a;
  assign alu_src_b_o  = bundle_q.alu_src_b;
  assign imm_src_o    = bundle_q.imm_src;
  assign result_src_o = bundle_q.result_src;
  assign mem_write_o  = bundle_q.mem_write;
  assign mem_read_o   = bundle_q.mem_read;
  assign mem_size_o   = bundle_q.mem_size;
  assign branch_o     = bundle_q.branch;
  assign br_cond_o    = bundle_q.br_cond;
  assign jump_o       = bundle_q.jump;
  assign jump_reg_o   = bundle_q.jump_reg;
  assign rs1_o        = bundle_q.rs1;
  assign rs2_o        = bundle_q.rs2;
  assign rd_o         = bundle_q.rd;

endmodule
